// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. The CPU writes a command byte to DATA. The
// block then holds the clock low to request to send, shifts the byte, odd parity
// and the stop bit out on device-generated clocks, and checks the device ACK.
// It drives both pins as open-collector pull-downs (oe = 1 pulls the line low).
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2500,
    parameter int unsigned TIMEOUT_CYCLES = 375000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       enable,
    input  logic       cs,
    input  logic       w_en,
    input  logic       address,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy
);

    // One counter serves both the inhibit period and the frame timeout.
    localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned FiltW  = $clog2(FILTER_LEN + 1);

    localparam logic [CntW-1:0]  InhLast  = CntW'(INHIBIT_CYCLES - 1);
    localparam logic [CntW-1:0]  ToLast   = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {StIdle, StInhibit, StSend, StAck, StWaitIdle} state_e;

    state_e            state_q, state_d;
    logic [1:0]        clk_sync_q, dat_sync_q;
    logic              clk_filt_q;
    logic [FiltW-1:0]  filt_cnt_q;
    logic [CntW-1:0]   cnt_q;
    logic [3:0]        bit_cnt_q;
    logic              dat_drv_q;
    logic [7:0]        data_q;
    logic              overrun_q, ack_err_q, timeout_q;

    logic clk_s, dat_s, fall;
    logic wr, wr_data, wr_status;
    logic inh_done, to_hit, ack_set, overrun_set;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];

    // Fall pulses in the cycle the filter accepts a 1->0 change.
    assign fall = clk_filt_q & ~clk_s & (filt_cnt_q == FiltLast);

    assign wr        = cs & w_en & enable;
    assign wr_data   = wr & ~address;
    assign wr_status = wr & address;

    assign inh_done    = (state_q == StInhibit) && (cnt_q == InhLast);
    assign to_hit      = (state_q inside {StSend, StAck, StWaitIdle}) && (cnt_q == ToLast);
    assign ack_set     = (state_q == StAck) && !to_hit && fall && dat_s;
    assign overrun_set = wr_data && (state_q != StIdle);

    // Two-flop synchronisers; idle bus level is high.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
        end
    end

    // Glitch filter: a new clock level must persist FILTER_LEN cycles.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            clk_filt_q <= 1'b1;
            filt_cnt_q <= '0;
        end else if (clk_s == clk_filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FiltLast) begin
            clk_filt_q <= clk_s;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM next state; timeout outranks a coincident clock fall.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (wr_data) state_d = StInhibit;
            StInhibit:  if (inh_done) state_d = StSend;
            StSend: begin
                if (to_hit)                         state_d = StIdle;
                else if (fall && bit_cnt_q == 4'd9) state_d = StAck;
            end
            StAck: begin
                if (to_hit)    state_d = StIdle;
                else if (fall) state_d = StWaitIdle;
            end
            StWaitIdle: begin
                if (to_hit)                  state_d = StIdle;
                else if (clk_filt_q && dat_s) state_d = StIdle;
            end
            default:    state_d = StIdle;
        endcase
    end

    // FSM outputs; decoded from state so reset releases the pins at once.
    always_comb begin
        busy       = (state_q != StIdle);
        ps2_clk_oe = (state_q == StInhibit);
        ps2_dat_oe = (state_q == StSend) && dat_drv_q;
    end

    // Shared inhibit/timeout counter, bit counter and bit driver.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            dat_drv_q <= 1'b0;
        end else begin
            if (state_q == StIdle || inh_done) cnt_q <= '0;
            else                               cnt_q <= cnt_q + 1'b1;

            if (inh_done) begin
                bit_cnt_q <= '0;
                dat_drv_q <= 1'b1;  // start bit
            end else if (state_q == StSend && fall && !to_hit) begin
                if (bit_cnt_q < 4'd8)       dat_drv_q <= ~data_q[bit_cnt_q[2:0]];
                else if (bit_cnt_q == 4'd8) dat_drv_q <= ~(~^data_q);
                else                        dat_drv_q <= 1'b0;  // stop bit
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

    // Data latch and sticky status flags; a set beats a same-cycle clear.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            overrun_q <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (wr_status) begin
                overrun_q <= 1'b0;
                ack_err_q <= 1'b0;
                timeout_q <= 1'b0;
            end
            if (wr_data && state_q == StIdle) begin
                data_q    <= din;
                ack_err_q <= 1'b0;
                timeout_q <= 1'b0;
            end
            if (to_hit)      timeout_q <= 1'b1;
            if (ack_set)     ack_err_q <= 1'b1;
            if (overrun_set) overrun_q <= 1'b1;
        end
    end

    // Register read mux.
    always_comb begin
        dout = address ? {busy, 4'b0000, overrun_q, ack_err_q, timeout_q} : data_q;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the DUT.
// The bits expected on the wire are queued when a DATA write is issued and are
// popped as the device samples them.
module tb_ps2_host_tx;

    localparam int unsigned INH = 50;
    localparam int unsigned TO  = 3000;
    localparam int unsigned FL  = 4;
    localparam int          H   = 20;  // device half period in clk25 cycles

    logic       clk25   = 1'b0;
    logic       rst     = 1'b1;
    logic       enable  = 1'b0;
    logic       cs      = 1'b0;
    logic       w_en    = 1'b0;
    logic       address = 1'b0;
    logic [7:0] din     = 8'h00;
    logic [7:0] dout;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe, busy;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int clk_low_cycles = 0;
    bit exp_q[$];

    // Open-collector bus: low if either side pulls.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (FL)
    ) dut (
        .clk25     (clk25),
        .rst       (rst),
        .enable    (enable),
        .cs        (cs),
        .w_en      (w_en),
        .address   (address),
        .din       (din),
        .dout      (dout),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy)
    );

    always #20 clk25 = ~clk25;

    always @(negedge clk25) if (ps2_clk_oe) clk_low_cycles++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_reg(input logic a, input logic [7:0] d);
        @(negedge clk25);
        cs = 1'b1; w_en = 1'b1; enable = 1'b1; address = a; din = d;
        @(negedge clk25);
        cs = 1'b0; w_en = 1'b0; enable = 1'b0;
    endtask

    task automatic read_reg(input logic a, output logic [7:0] v);
        address = a;
        #1;
        v = dout;
    endtask

    // Wire order: start 0, d0..d7, odd parity, stop 1.
    task automatic expect_frame(input logic [7:0] b);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        exp_q.push_back(~^b);
        exp_q.push_back(1'b1);
    endtask

    // Device: waits for request-to-send, samples data in each clock-high phase,
    // then produces a falling edge. On the 11th fall it drives the ACK value.
    task automatic device_frame(input bit ack_val, input int nfalls);
        int  waited;
        bit  s;
        bit  e;
        waited = 0;
        while (!(ps2_clk_in && !ps2_dat_in) && waited < int'(INH) + 200) begin
            @(negedge clk25);
            waited++;
        end
        check("start_seen", {31'b0, ps2_clk_in && !ps2_dat_in}, 32'd1);
        if (!(ps2_clk_in && !ps2_dat_in)) return;
        repeat (H) @(negedge clk25);
        for (int k = 0; k < nfalls; k++) begin
            repeat (H / 2) @(negedge clk25);
            s = ps2_dat_in;
            check("sb_nonempty", {31'b0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("wire_bit%0d", k), {31'b0, s}, {31'b0, e});
            end
            repeat (H / 2) @(negedge clk25);
            dev_clk_low = 1'b1;
            if (k == 10) dev_dat_low = ~ack_val;
            repeat (H) @(negedge clk25);
            dev_clk_low = 1'b0;
        end
        if (nfalls == 11) begin
            repeat (H) @(negedge clk25);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk25);
            n++;
        end
        check("busy_fall", {31'b0, busy}, 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack_val, input logic [7:0] exp_st);
        int         c0;
        logic [7:0] v;
        c0 = clk_low_cycles;
        write_reg(1'b0, b);
        expect_frame(b);
        device_frame(ack_val, 11);
        check("inhibit_len", clk_low_cycles - c0, INH);
        wait_idle();
        read_reg(1'b1, v);
        check("status_after", {24'b0, v}, {24'b0, exp_st});
        read_reg(1'b0, v);
        check("data_after", {24'b0, v}, {24'b0, b});
        check("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] v;
        int         n;

        repeat (3) @(negedge clk25);
        rst = 1'b0;
        @(negedge clk25);
        check("rst_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
        check("rst_dat_oe", {31'b0, ps2_dat_oe}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        read_reg(1'b0, v);
        check("rst_data", {24'b0, v}, 32'h00);
        read_reg(1'b1, v);
        check("rst_status", {24'b0, v}, 32'h00);

        // Normal frames, including both parity polarities.
        run_frame(8'hED, 1'b0, 8'h00);
        run_frame(8'h01, 1'b0, 8'h00);
        run_frame(8'h00, 1'b0, 8'h00);

        // Silent device: timeout measured from clock release.
        write_reg(1'b0, 8'hFF);
        n = 0;
        while (!(ps2_dat_oe && !ps2_clk_oe) && n < int'(INH) + 100) begin
            @(negedge clk25);
            n++;
        end
        check("release_seen", {31'b0, ps2_dat_oe && !ps2_clk_oe}, 32'd1);
        n = 0;
        while (ps2_dat_oe && n < int'(TO) + 100) begin
            n++;
            @(negedge clk25);
        end
        check("timeout_len", n, TO);
        check("to_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
        check("to_dat_oe", {31'b0, ps2_dat_oe}, 32'd0);
        read_reg(1'b1, v);
        check("to_status", {24'b0, v}, 32'h01);
        write_reg(1'b1, 8'h00);
        read_reg(1'b1, v);
        check("to_cleared", {24'b0, v}, 32'h00);

        // NACK from device, then a fresh write clears the error.
        run_frame(8'h3C, 1'b1, 8'h02);
        run_frame(8'hA7, 1'b0, 8'h00);

        // Overrun: second write while busy is dropped.
        write_reg(1'b0, 8'h5A);
        expect_frame(8'h5A);
        write_reg(1'b0, 8'h55);
        read_reg(1'b0, v);
        check("ovr_data", {24'b0, v}, 32'h5A);
        read_reg(1'b1, v);
        check("ovr_status_busy", {24'b0, v}, 32'h84);
        device_frame(1'b0, 11);
        wait_idle();
        read_reg(1'b1, v);
        check("ovr_status_done", {24'b0, v}, 32'h04);
        read_reg(1'b0, v);
        check("ovr_data_done", {24'b0, v}, 32'h5A);
        write_reg(1'b1, 8'hFF);
        read_reg(1'b1, v);
        check("ovr_cleared", {24'b0, v}, 32'h00);

        // Reset while d4 of 0xA5 (a 0, so data is pulled low) is on the wire.
        write_reg(1'b0, 8'hA5);
        expect_frame(8'hA5);
        device_frame(1'b0, 5);
        check("mid_busy", {31'b0, busy}, 32'd1);
        check("mid_dat_oe", {31'b0, ps2_dat_oe}, 32'd1);
        exp_q.delete();
        #3;
        rst = 1'b1;
        #1;
        check("arst_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
        check("arst_dat_oe", {31'b0, ps2_dat_oe}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        read_reg(1'b1, v);
        check("arst_status", {24'b0, v}, 32'h00);
        read_reg(1'b0, v);
        check("arst_data", {24'b0, v}, 32'h00);
        @(negedge clk25);
        rst = 1'b0;
        repeat (4) @(negedge clk25);

        run_frame(8'h96, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
